// File: rtl/instr_issue_ctrl.sv
// Instruction queue and issue sequencer in front of the decoder: circular buffer of
// (pc, instr) pairs, issued one per cycle when ROB+RS or ROB+LSB have room.
module instr_issue_ctrl #(
   parameter int IQ_DEPTH_LOG = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instr,
   output logic        if_ready,
   input  logic        rob_full,
   input  logic        rs_full,
   input  logic        lsb_full,
   input  logic        jalr_done,
   input  logic        flush_in,
   output logic        dec_valid,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr
);

   localparam int DEPTH = 1 << IQ_DEPTH_LOG;
   localparam int PW    = IQ_DEPTH_LOG + 1;
   localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
   localparam logic [PW-1:0] LAST_W  = PW'(DEPTH - 1);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   instr_q [DEPTH];
   logic [PW-1:0] head, tail, count;
   logic [1:0]    state;

   logic [31:0] head_pc, head_instr;
   logic [6:0]  head_op;
   logic        head_is_mem, res_free, do_push, do_pop;

   // Pointers stay in 0..DEPTH-1; the extra bit only gives count room to reach DEPTH.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_W) ? '0 : p + PW'(1);
   endfunction

   assign head_pc     = pc_q[head[IQ_DEPTH_LOG-1:0]];
   assign head_instr  = instr_q[head[IQ_DEPTH_LOG-1:0]];
   assign head_op     = head_instr[6:0];
   assign head_is_mem = (head_op == OP_LOAD) || (head_op == OP_STORE);
   assign res_free    = !rob_full && (head_is_mem ? !lsb_full : !rs_full);

   assign if_ready = (count < DEPTH_W) && (state != ST_FLUSH);
   assign do_push  = rdy_in && !flush_in && if_valid && if_ready;
   assign do_pop   = rdy_in && !flush_in && (state == ST_RUN) && (count != '0) && res_free;

   always_ff @(posedge clk_in) begin
      if (do_push) begin
         pc_q[tail[IQ_DEPTH_LOG-1:0]]    <= if_pc;
         instr_q[tail[IQ_DEPTH_LOG-1:0]] <= if_instr;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         state     <= ST_RUN;
         dec_valid <= 1'b0;
         dec_pc    <= '0;
         dec_instr <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            // Flush wins over any same-cycle push, pop or jalr_done.
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            dec_valid <= 1'b0;
            state     <= ST_FLUSH;
         end else begin
            dec_valid <= do_pop;
            if (do_push) tail <= ptr_inc(tail);
            if (do_pop) begin
               head      <= ptr_inc(head);
               dec_pc    <= head_pc;
               dec_instr <= head_instr;
            end
            if (do_push && !do_pop)      count <= count + PW'(1);
            else if (!do_push && do_pop) count <= count - PW'(1);
            case (state)
               ST_RUN:   if (do_pop && head_op == OP_JALR) state <= ST_HOLD;
               ST_HOLD:  if (jalr_done) state <= ST_RUN;
               ST_FLUSH: state <= ST_RUN;
               default:  state <= ST_RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl: reset, fill, class gating, JALR hold, flush, pause/wrap.
module tb_instr_issue_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, if_valid, rob_full, rs_full, lsb_full, jalr_done, flush_in;
   logic [31:0] if_pc, if_instr;
   logic        if_ready, dec_valid;
   logic [31:0] dec_pc, dec_instr;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] ADDI = 32'h00100093;
   localparam logic [31:0] ADD  = 32'h00208033;
   localparam logic [31:0] JALR = 32'h000080E7;
   localparam logic [31:0] LW   = 32'h00002003;

   instr_issue_ctrl #(.IQ_DEPTH_LOG(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
      .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
      .jalr_done(jalr_done), .flush_in(flush_in),
      .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [31:0] mk_addi(input int k);
      return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
   endfunction

   task automatic test_reset();
      rst_in = 1'b0; rdy_in = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; jalr_done = 1'b0; flush_in = 1'b0;
      tick(); tick();
      checks++;
      if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_instr !== 32'h0 || if_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: valid=%b pc=%h instr=%h rdy=%b, want 0/0/0/1",
                  dec_valid, dec_pc, dec_instr, if_ready);
      end
      rst_in = 1'b1;
      tick();
      rs_full = 1'b1; if_valid = 1'b1; if_instr = ADDI;
      for (int i = 0; i < 3; i++) begin
         if_pc = 32'h100 + 32'(4 * i);
         tick();
      end
      if_valid = 1'b0; rs_full = 1'b0;
      tick();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin
         errors++;
         $display("FAIL reset_pre_issue: valid=%b pc=%h, want 1/00000100", dec_valid, dec_pc);
      end
      rst_in = 1'b0;
      #1;
      checks++;
      if (dec_valid !== 1'b0 || dec_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_async: valid=%b pc=%h, want 0/0", dec_valid, dec_pc);
      end
      tick();
      rst_in = 1'b1;
      tick();
      checks++;
      if (if_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_if_ready: got %b want 1", if_ready);
      end
      tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_empty: dec_valid=%b want 0 (queue must be empty)", dec_valid);
      end
   endtask

   task automatic test_fill();
      rs_full = 1'b1; if_valid = 1'b1; if_instr = ADDI;
      for (int i = 0; i < 8; i++) begin
         if_pc = 32'h200 + 32'(4 * i);
         checks++;
         if (if_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready_%0d: got %b want 1", i, if_ready);
         end
         tick();
      end
      checks++;
      if (if_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: if_ready=%b want 0", if_ready);
      end
      if_pc = 32'h300;
      tick();
      if_valid = 1'b0; rs_full = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (dec_valid !== 1'b1 || dec_pc !== 32'h200 + 32'(4 * i)) begin
            errors++;
            $display("FAIL fill_drain_%0d: valid=%b pc=%h want 1/%h",
                     i, dec_valid, dec_pc, 32'h200 + 32'(4 * i));
         end
      end
      tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_ninth_rejected: dec_valid=%b pc=%h want 0", dec_valid, dec_pc);
      end
   endtask

   task automatic test_class_gating();
      lsb_full = 1'b1; rs_full = 1'b0;
      if_valid = 1'b1; if_pc = 32'h400; if_instr = LW;
      tick();
      if_valid = 1'b0;
      tick(); tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL class_lw_blocked: dec_valid=%b want 0", dec_valid);
      end
      lsb_full = 1'b0;
      tick();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h400 || dec_instr !== LW) begin
         errors++;
         $display("FAIL class_lw_issue: valid=%b pc=%h instr=%h want 1/400/%h",
                  dec_valid, dec_pc, dec_instr, LW);
      end
      // A non-memory head must ignore lsb_full but respect rob_full.
      lsb_full = 1'b1; rob_full = 1'b1;
      if_valid = 1'b1; if_pc = 32'h410; if_instr = ADDI;
      tick();
      if_valid = 1'b0;
      tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL class_rob_blocked: dec_valid=%b want 0", dec_valid);
      end
      rob_full = 1'b0;
      tick();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h410) begin
         errors++;
         $display("FAIL class_alu_issue: valid=%b pc=%h want 1/410", dec_valid, dec_pc);
      end
      lsb_full = 1'b0;
      tick();
   endtask

   task automatic test_jalr();
      if_valid = 1'b1; if_pc = 32'h500; if_instr = JALR;
      tick();
      if_pc = 32'h504; if_instr = ADD;
      tick();
      if_valid = 1'b0;
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h500) begin
         errors++;
         $display("FAIL jalr_issue: valid=%b pc=%h want 1/500", dec_valid, dec_pc);
      end
      tick(); tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL jalr_hold: dec_valid=%b pc=%h want 0", dec_valid, dec_pc);
      end
      jalr_done = 1'b1;
      tick();
      jalr_done = 1'b0;
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL jalr_done_cycle: dec_valid=%b want 0", dec_valid);
      end
      tick();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h504 || dec_instr !== ADD) begin
         errors++;
         $display("FAIL jalr_resume: valid=%b pc=%h instr=%h want 1/504/%h",
                  dec_valid, dec_pc, dec_instr, ADD);
      end
      tick();
   endtask

   task automatic test_flush();
      rs_full = 1'b1; if_valid = 1'b1; if_instr = ADDI;
      for (int i = 0; i < 5; i++) begin
         if_pc = 32'h600 + 32'(4 * i);
         tick();
      end
      flush_in = 1'b1; if_pc = 32'h700;
      tick();
      flush_in = 1'b0; if_valid = 1'b0; rs_full = 1'b0;
      checks++;
      if (if_ready !== 1'b0 || dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drain: if_ready=%b dec_valid=%b want 0/0", if_ready, dec_valid);
      end
      tick();
      checks++;
      if (if_ready !== 1'b1 || dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_run: if_ready=%b dec_valid=%b want 1/0", if_ready, dec_valid);
      end
      tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty: dec_valid=%b pc=%h want 0", dec_valid, dec_pc);
      end
   endtask

   task automatic test_pause_wrap();
      int          pushed = 0;
      int          popped = 0;
      logic        acc, rdy_now, prev_v;
      logic [31:0] prev_pc;
      for (int cyc = 0; cyc < 400 && popped < 20; cyc++) begin
         rdy_in   = ($urandom_range(0, 3) != 0);
         rs_full  = ($urandom_range(0, 2) == 0);
         if_valid = (pushed < 20);
         if_pc    = 32'h800 + 32'(4 * pushed);
         if_instr = mk_addi(pushed);
         acc      = if_valid && if_ready && rdy_in;
         rdy_now  = rdy_in;
         prev_v   = dec_valid;
         prev_pc  = dec_pc;
         tick();
         if (acc) pushed++;
         if (!rdy_now) begin
            checks++;
            if (dec_valid !== prev_v || dec_pc !== prev_pc) begin
               errors++;
               $display("FAIL wrap_pause_hold: valid=%b pc=%h want %b/%h",
                        dec_valid, dec_pc, prev_v, prev_pc);
            end
         end else if (dec_valid) begin
            checks++;
            if (dec_pc !== 32'h800 + 32'(4 * popped) || dec_instr !== mk_addi(popped)) begin
               errors++;
               $display("FAIL wrap_order_%0d: pc=%h instr=%h want %h/%h", popped, dec_pc,
                        dec_instr, 32'h800 + 32'(4 * popped), mk_addi(popped));
            end
            popped++;
         end
      end
      rdy_in = 1'b1; if_valid = 1'b0; rs_full = 1'b0;
      checks++;
      if (popped != 20 || pushed != 20) begin
         errors++;
         $display("FAIL wrap_count: popped=%0d pushed=%0d want 20/20", popped, pushed);
      end
      tick();
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL wrap_no_dup: dec_valid=%b pc=%h want 0", dec_valid, dec_pc);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_class_gating();
      test_jalr();
      test_flush();
      test_pause_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
